// File: rtl/broadcast_sequencer_if.sv
// Handshake bundle between the broadcast sequencer, the cell particle memories
// and the force-filter bank.
interface broadcast_sequencer_if #(
  parameter int PARTICLE_ID_WIDTH = 7
) ();
  logic                         start;
  logic                         flush;
  logic [PARTICLE_ID_WIDTH-1:0] home_count;
  logic                         cnt_req;
  logic                         cnt_valid;
  logic [PARTICLE_ID_WIDTH-1:0] nb_count;
  logic                         filter_ready;
  logic [PARTICLE_ID_WIDTH-1:0] ref_id;
  logic                         nb_rd_en;
  logic [PARTICLE_ID_WIDTH-1:0] nb_rd_addr;
  logic                         ref_done;
  logic                         all_done;
  logic                         busy;

  modport master (
    output start, flush, home_count, cnt_valid, nb_count, filter_ready,
    input  cnt_req, ref_id, nb_rd_en, nb_rd_addr, ref_done, all_done, busy
  );

  modport slave (
    input  start, flush, home_count, cnt_valid, nb_count, filter_ready,
    output cnt_req, ref_id, nb_rd_en, nb_rd_addr, ref_done, all_done, busy
  );
endinterface

// File: rtl/broadcast_sequencer.sv
// Per-home-cell controller: walks reference particles and broadcasts every
// neighbor particle into the filter pipeline under back-pressure.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | waiting for start; home_count latched on accepted start
// S_LOAD_REF  | ref_id valid; schedule the one-cycle neighbor count request
// S_WAIT_CNT  | cnt_req pulse visible; hold until cnt_valid, latch nb_count
// S_BROADCAST | issue neighbor reads 1..nb_count while filter is ready
// S_NEXT_REF  | advance ref_id or finish the home cell
// S_DONE      | schedule the all_done pulse, return to idle
module broadcast_sequencer #(
  parameter int PARTICLE_ID_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  broadcast_sequencer_if.slave  bus
);
  localparam int W = PARTICLE_ID_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_REF,
    S_WAIT_CNT,
    S_BROADCAST,
    S_NEXT_REF,
    S_DONE
  } state_t;

  state_t         state, state_nx;
  logic [W-1:0]   home_cnt, home_cnt_nx;
  logic [W-1:0]   nb_cnt, nb_cnt_nx;
  logic [W-1:0]   ref_id_q, ref_id_nx;
  logic [W-1:0]   addr_q, addr_nx;
  logic           cnt_req_q, cnt_req_nx;
  logic           rd_en_q, rd_en_nx;
  logic           ref_done_q, ref_done_nx;
  logic           all_done_q, all_done_nx;
  logic           busy_q, busy_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      home_cnt   <= '0;
      nb_cnt     <= '0;
      ref_id_q   <= '0;
      addr_q     <= '0;
      cnt_req_q  <= 1'b0;
      rd_en_q    <= 1'b0;
      ref_done_q <= 1'b0;
      all_done_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_nx;
      home_cnt   <= home_cnt_nx;
      nb_cnt     <= nb_cnt_nx;
      ref_id_q   <= ref_id_nx;
      addr_q     <= addr_nx;
      cnt_req_q  <= cnt_req_nx;
      rd_en_q    <= rd_en_nx;
      ref_done_q <= ref_done_nx;
      all_done_q <= all_done_nx;
      busy_q     <= busy_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    home_cnt_nx = home_cnt;
    nb_cnt_nx   = nb_cnt;
    ref_id_nx   = ref_id_q;
    addr_nx     = addr_q;
    cnt_req_nx  = 1'b0;
    rd_en_nx    = 1'b0;
    ref_done_nx = 1'b0;
    all_done_nx = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          home_cnt_nx = bus.home_count;
          if (bus.home_count == '0) begin
            state_nx = S_DONE;
          end else begin
            ref_id_nx = W'(1);
            state_nx  = S_LOAD_REF;
          end
        end
      end
      S_LOAD_REF: begin
        cnt_req_nx = 1'b1;
        state_nx   = S_WAIT_CNT;
      end
      S_WAIT_CNT: begin
        if (bus.cnt_valid) begin
          nb_cnt_nx = bus.nb_count;
          if (bus.nb_count == '0) begin
            ref_done_nx = 1'b1;
            state_nx    = S_NEXT_REF;
          end else begin
            addr_nx  = W'(1);
            state_nx = S_BROADCAST;
          end
        end
      end
      S_BROADCAST: begin
        // Equality against the latched count: the last address is never
        // incremented, so a full-scale count cannot wrap to zero.
        if (rd_en_q && (addr_q == nb_cnt)) begin
          state_nx = S_NEXT_REF;
        end else begin
          if (rd_en_q) addr_nx = addr_q + 1'b1;
          rd_en_nx    = bus.filter_ready;
          ref_done_nx = bus.filter_ready && (addr_nx == nb_cnt);
        end
      end
      S_NEXT_REF: begin
        if (ref_id_q == home_cnt) begin
          state_nx = S_DONE;
        end else begin
          ref_id_nx = ref_id_q + 1'b1;
          state_nx  = S_LOAD_REF;
        end
      end
      S_DONE: begin
        all_done_nx = 1'b1;
        state_nx    = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase

    if (bus.flush) begin
      state_nx    = S_IDLE;
      home_cnt_nx = '0;
      nb_cnt_nx   = '0;
      ref_id_nx   = '0;
      addr_nx     = '0;
      cnt_req_nx  = 1'b0;
      rd_en_nx    = 1'b0;
      ref_done_nx = 1'b0;
      all_done_nx = 1'b0;
    end

    busy_nx = (state_nx != S_IDLE);
  end

  assign bus.cnt_req    = cnt_req_q;
  assign bus.ref_id     = ref_id_q;
  assign bus.nb_rd_en   = rd_en_q;
  assign bus.nb_rd_addr = addr_q;
  assign bus.ref_done   = ref_done_q;
  assign bus.all_done   = all_done_q;
  assign bus.busy       = busy_q;
endmodule
